div_sequencer: RTL
==================

DIV_SEQUENCER -- requirements
Module: div_sequencer

Interface
REQ-001 SHALL have parameter DIVIDENDLEN, default 8, dividend and quotient width.
REQ-002 SHALL have parameter DIVISORLEN, default 4, divisor and remainder width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port in_valid  input  1  request operands valid.
REQ-006 SHALL have port in_ready  output  1  sequencer can accept operands.
REQ-007 SHALL have port dividend  input  DIVIDENDLEN  unsigned dividend.
REQ-008 SHALL have port divisor  input  DIVISORLEN  unsigned divisor.
REQ-009 SHALL have port out_valid  output  1  result valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port quotient  output  DIVIDENDLEN  unsigned quotient.
REQ-012 SHALL have port remainder  output  DIVISORLEN  unsigned remainder.
REQ-013 SHALL have port div_by_zero  output  1  result came from a zero divisor.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DONE.
REQ-015 SHALL drive in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-016 SHALL accept on in_valid&&in_ready: latch dividend into quotient shift register, divisor into divisor register, clear partial remainder (DIVISORLEN+1 bits), load step counter with DIVIDENDLEN-1.
REQ-017 SHALL move IDLE->RUN on acceptance when divisor!=0; IDLE->DONE with div_by_zero=1 when divisor==0.
REQ-018 SHALL perform one restoring step per RUN cycle, MSB first: R={R[DIVISORLEN-1:0], next dividend bit}; if R>=divisor then R=R-divisor and quotient bit=1, else quotient bit=0.
REQ-019 SHALL decrement the counter each RUN cycle and move RUN->DONE on the step where counter==0; exactly DIVIDENDLEN RUN cycles.
REQ-020 SHALL assert out_valid on the clock edge DIVIDENDLEN+1 edges after the acceptance edge for nonzero divisor, and 1 edge after for zero divisor.
REQ-021 SHALL, on zero divisor, present quotient all ones and remainder = dividend[DIVISORLEN-1:0].
REQ-022 SHALL hold quotient, remainder, div_by_zero stable in DONE while out_ready=0, for any number of cycles.
REQ-023 SHALL move DONE->IDLE on out_valid&&out_ready; in_ready rises the following cycle (no same-cycle accept in DONE).
REQ-024 SHALL ignore in_valid, dividend, divisor outside IDLE.
REQ-025 SHALL keep remainder < divisor for all nonzero divisors; quotient*divisor+remainder==dividend.

Reset
REQ-026 SHALL, on rst_n low, asynchronously enter IDLE with in_ready=1, out_valid=0, quotient=0, remainder=0, div_by_zero=0, counter=0.
REQ-027 SHALL abandon any RUN/DONE operation on reset mid-operation; no result emitted after release.
REQ-028 SHALL accept a new request on the first rising edge with rst_n high.

Structure
REQ-029 SHALL place the state enum (IDLE/RUN/DONE) and a packed result struct {quotient, remainder, div_by_zero} in shared package div_pkg.
REQ-030 SHALL isolate the combinational compare/subtract step in sub-module div_step (inputs partial remainder, divisor; outputs next remainder, quotient bit).
REQ-031 SHALL contain all sequencing (FSM, counter, shift registers) in div_sequencer.

Verification
REQ-032 SHALL cover 200/7 -> quotient=28, remainder=4, div_by_zero=0, out_valid 9 edges after accept.
REQ-033 SHALL cover 25/0 -> quotient=0xFF, remainder=9, div_by_zero=1, out_valid 1 edge after accept.
REQ-034 SHALL cover 13/3 with out_ready low 5 cycles -> quotient=4, remainder=1 held stable, in_ready=0 throughout, IDLE one edge after out_ready rises.
REQ-035 SHALL cover rst_n low on 4th RUN cycle of 255/15 -> immediate IDLE, all outputs at reset values, no out_valid after release; then 255/15 -> 17 rem 0.
REQ-036 SHALL cover exhaustive sweep of all 2^12 {divisor,dividend} pairs, back-to-back with out_ready=1 -> every result matches / and %, zeros per REQ-021.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types for the restoring divider: FSM state encoding and the result record.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Result fields are sized for the widest supported operand (< 32 bits).
  localparam int RES_W = 32;

  typedef struct packed {
    logic [RES_W-1:0] quotient;
    logic [RES_W-1:0] remainder;
    logic             div_by_zero;
  } div_result_t;

  function automatic div_result_t make_result(input logic [RES_W-1:0] q,
                                              input logic [RES_W-1:0] r,
                                              input logic             dbz);
    div_result_t res;
    res.quotient    = q;
    res.remainder   = r;
    res.div_by_zero = dbz;
    return res;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: conditional subtract of the divisor from the
// shifted partial remainder, yielding the next remainder and one quotient bit.
module div_step #(
  parameter int DIVISORLEN = 4
) (
  input  logic [DIVISORLEN:0]   i_rem,
  input  logic [DIVISORLEN-1:0] i_divisor,
  output logic [DIVISORLEN:0]   o_rem,
  output logic                  o_qbit
);

  logic [DIVISORLEN:0] w_div_ext;

  assign w_div_ext = {1'b0, i_divisor};
  assign o_qbit    = (i_rem >= w_div_ext);
  assign o_rem     = o_qbit ? (i_rem - w_div_ext) : i_rem;

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle unsigned restoring divider, one quotient bit per RUN cycle, MSB first.
// Handshake: a request is taken on in_valid && in_ready (IDLE only); a result is
// released on out_valid && out_ready (DONE only), and both sides hold until then.
module div_sequencer
  import div_pkg::*;
#(
  parameter int DIVIDENDLEN = 8,
  parameter int DIVISORLEN  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DIVIDENDLEN-1:0] dividend,
  input  logic [DIVISORLEN-1:0]  divisor,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DIVIDENDLEN-1:0] quotient,
  output logic [DIVISORLEN-1:0]  remainder,
  output logic                   div_by_zero,
  output state_t                 dbg_state
);

  localparam int CNT_W = (DIVIDENDLEN > 1) ? $clog2(DIVIDENDLEN) : 1;

  state_t                 r_state;
  state_t                 w_next_state;
  logic [DIVIDENDLEN-1:0] r_quot;
  logic [DIVISORLEN-1:0]  r_div;
  logic [DIVISORLEN:0]    r_rem;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_dbz;

  logic                   w_accept;
  logic                   w_zero_div;
  logic                   w_last_step;
  logic                   w_qbit;
  logic [DIVISORLEN:0]    w_shift;
  logic [DIVISORLEN:0]    w_step_rem;
  div_result_t            w_result;
  logic                   w_unused;

  assign w_accept    = in_valid && (r_state == IDLE);
  assign w_zero_div  = (divisor == '0);
  assign w_last_step = (r_cnt == '0);
  // The quotient register doubles as the dividend shifter: its MSB feeds the remainder.
  assign w_shift     = {r_rem[DIVISORLEN-1:0], r_quot[DIVIDENDLEN-1]};

  div_step #(
    .DIVISORLEN(DIVISORLEN)
  ) u_step (
    .i_rem    (w_shift),
    .i_divisor(r_div),
    .o_rem    (w_step_rem),
    .o_qbit   (w_qbit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (w_accept) begin
          w_next_state = w_zero_div ? DONE : RUN;
        end
      end
      RUN: begin
        if (w_last_step) begin
          w_next_state = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_quot <= '0;
      r_div  <= '0;
      r_rem  <= '0;
      r_cnt  <= '0;
      r_dbz  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_div <= divisor;
            r_cnt <= CNT_W'(DIVIDENDLEN - 1);
            if (w_zero_div) begin
              r_quot <= '1;
              r_rem  <= {1'b0, dividend[DIVISORLEN-1:0]};
              r_dbz  <= 1'b1;
            end else begin
              r_quot <= dividend;
              r_rem  <= '0;
              r_dbz  <= 1'b0;
            end
          end
        end
        RUN: begin
          r_rem  <= w_step_rem;
          r_quot <= {r_quot[DIVIDENDLEN-2:0], w_qbit};
          if (!w_last_step) begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign w_result    = make_result(RES_W'(r_quot), RES_W'(r_rem[DIVISORLEN-1:0]), r_dbz);
  assign quotient    = w_result.quotient[DIVIDENDLEN-1:0];
  assign remainder   = w_result.remainder[DIVISORLEN-1:0];
  assign div_by_zero = w_result.div_by_zero;
  assign dbg_state   = r_state;

  // Upper result bits are zero padding; the remainder MSB is zero after every step.
  assign w_unused = ^{w_result.quotient[RES_W-1:DIVIDENDLEN],
                      w_result.remainder[RES_W-1:DIVISORLEN], r_rem[DIVISORLEN]};

endmodule
